// File: rtl/cdu_pkg.sv
//==============================================================================
// Module      : cdu_pkg
// Description : Shared types and default constants for the CDU read-counter
//               channel sequencer.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package cdu_pkg;

  // Sequencer state; the encoding is visible on the mode output.
  typedef enum logic [1:0] {
    ZERO   = 2'd0,
    SETTLE = 2'd1,
    COARSE = 2'd2,
    FINE   = 2'd3
  } seq_state_t;

  // Width of the rate divider and of the settle/hold counters.
  localparam int DIV_W = 8;

  // Default timing in CLOCKH (51.2 kHz) cycles.
  localparam int HI_DIV_DEFAULT    = 4;   // 12.8 kpps in COARSE
  localparam int LO_DIV_DEFAULT    = 64;  // 800 pps in FINE
  localparam int SETTLE_DEFAULT    = 16;
  localparam int FINE_HOLD_DEFAULT = 8;

endpackage : cdu_pkg

`default_nettype wire

// File: rtl/cdu_count_sequencer_if.sv
//==============================================================================
// Module      : cdu_count_sequencer_if
// Description : Comparator / read-counter / AGC signal bundle for one CDU
//               read-counter channel. The test-point outputs ATPC1/ATPF1
//               exist only when CDU_SEQ_TP_EN is defined.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

interface cdu_count_sequencer_if;

  // Control and comparator inputs to the sequencer
  logic AGCZ;
  logic AGCEEC;
  logic coarse_err;
  logic fine_err;
  logic err_dir;

  // Read-counter and AGC outputs from the sequencer
  logic cnt_up;
  logic cnt_dn;
  logic cnt_clr;
  logic ATpPGH;
  logic ATmPGH;
  cdu_pkg::seq_state_t mode;

`ifdef CDU_SEQ_TP_EN
  logic ATPC1;
  logic ATPF1;
`endif

  // Environment side: drives the comparators/AGC controls, observes strobes
  modport master (
    output AGCZ, AGCEEC, coarse_err, fine_err, err_dir,
`ifdef CDU_SEQ_TP_EN
    input  ATPC1, ATPF1,
`endif
    input  cnt_up, cnt_dn, cnt_clr, ATpPGH, ATmPGH, mode
  );

  // Sequencer side
  modport slave (
    input  AGCZ, AGCEEC, coarse_err, fine_err, err_dir,
`ifdef CDU_SEQ_TP_EN
    output ATPC1, ATPF1,
`endif
    output cnt_up, cnt_dn, cnt_clr, ATpPGH, ATmPGH, mode
  );

endinterface : cdu_count_sequencer_if

`default_nettype wire

// File: rtl/cdu_rate_div.sv
//==============================================================================
// Module      : cdu_rate_div
// Description : Free-running modulo-DIV counter with synchronous restart.
//               tc is high while the count sits at DIV-1; the count wraps
//               to zero on the following edge.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cdu_rate_div #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             restart,
  input  logic [WIDTH-1:0] div,
  output logic             tc
);

  logic [WIDTH-1:0] count;

  assign tc = (count == (div - WIDTH'(1)));

  // Count 0..div-1, wrapping at terminal count or on restart
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (restart || tc) begin
      count <= '0;
    end else begin
      count <= count + WIDTH'(1);
    end
  end

endmodule : cdu_rate_div

`default_nettype wire

// File: rtl/cdu_count_sequencer.sv
//==============================================================================
// Module      : cdu_count_sequencer
// Description : Mode controller for one CDU read-counter channel. Steps
//               ZERO -> SETTLE -> COARSE/FINE and issues rate-limited
//               up/down strobes to the read counter, mirrored onto
//               ATpPGH/ATmPGH when AGCEEC is set.
//               Optional: define CDU_SEQ_TP_EN to add the ATPC1/ATPF1
//               mode test points.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cdu_count_sequencer #(
  parameter int HI_DIV    = cdu_pkg::HI_DIV_DEFAULT,
  parameter int LO_DIV    = cdu_pkg::LO_DIV_DEFAULT,
  parameter int SETTLE    = cdu_pkg::SETTLE_DEFAULT,
  parameter int FINE_HOLD = cdu_pkg::FINE_HOLD_DEFAULT
) (
  input  logic                  CLOCKH,
  input  logic                  rst_n,
  cdu_count_sequencer_if.slave  bus
);

  import cdu_pkg::*;

  localparam logic [DIV_W-1:0] HI_DIV_V    = DIV_W'(HI_DIV);
  localparam logic [DIV_W-1:0] LO_DIV_V    = DIV_W'(LO_DIV);
  localparam logic [DIV_W-1:0] SETTLE_LAST = DIV_W'(SETTLE - 1);
  localparam logic [DIV_W-1:0] HOLD_LAST   = DIV_W'(FINE_HOLD - 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic [DIV_W-1:0] settle_cnt;
  logic [DIV_W-1:0] hold_cnt;
  logic [DIV_W-1:0] div_val;
  logic             dir_q;
  logic             running;
  logic             leave;
  logic             want;
  logic             restart;
  logic             tc;

  // Next-state decision; AGCZ low overrides everything
  always_comb begin
    next_state = state;
    if (!bus.AGCZ) begin
      next_state = cdu_pkg::ZERO;
    end else begin
      case (state)
        cdu_pkg::ZERO:   next_state = cdu_pkg::SETTLE;
        cdu_pkg::SETTLE: if (settle_cnt == SETTLE_LAST)
                           next_state = bus.coarse_err ? cdu_pkg::COARSE : cdu_pkg::FINE;
        cdu_pkg::COARSE: if (!bus.coarse_err && (hold_cnt == HOLD_LAST))
                           next_state = cdu_pkg::FINE;
        cdu_pkg::FINE:   if (bus.coarse_err)
                           next_state = cdu_pkg::COARSE;
        default:         next_state = cdu_pkg::ZERO;
      endcase
    end
  end

  // Divider control: run only while staying in COARSE/FINE; any state
  // change restarts it so a pending partial period is discarded.
  always_comb begin
    running = (state == cdu_pkg::COARSE) || (state == cdu_pkg::FINE);
    leave   = (next_state != state);
    restart = !running || leave;
    div_val = (state == cdu_pkg::FINE) ? LO_DIV_V : HI_DIV_V;
    want    = tc && !leave &&
              ((state == cdu_pkg::COARSE) ||
               ((state == cdu_pkg::FINE) && bus.fine_err));
  end

  cdu_rate_div #(
    .WIDTH   (DIV_W)
  ) u_div (
    .clk     (CLOCKH),
    .rst_n   (rst_n),
    .restart (restart),
    .div     (div_val),
    .tc      (tc)
  );

  assign bus.mode = state;

  // Sequencer state, counters, direction memory and registered outputs
  always_ff @(posedge CLOCKH or negedge rst_n) begin
    if (!rst_n) begin
      state       <= cdu_pkg::ZERO;
      settle_cnt  <= '0;
      hold_cnt    <= '0;
      dir_q       <= 1'b0;
      bus.cnt_clr <= 1'b1;
      bus.cnt_up  <= 1'b0;
      bus.cnt_dn  <= 1'b0;
      bus.ATpPGH  <= 1'b0;
      bus.ATmPGH  <= 1'b0;
`ifdef CDU_SEQ_TP_EN
      bus.ATPC1   <= 1'b0;
      bus.ATPF1   <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      // The counter is cleared exactly when the next state is ZERO.
      bus.cnt_clr <= !bus.AGCZ;
`ifdef CDU_SEQ_TP_EN
      bus.ATPC1   <= (next_state == cdu_pkg::COARSE);
      bus.ATPF1   <= (next_state == cdu_pkg::FINE);
`endif

      settle_cnt <= ((state == cdu_pkg::SETTLE) && (next_state == cdu_pkg::SETTLE))
                    ? settle_cnt + DIV_W'(1) : '0;
      hold_cnt   <= ((state == cdu_pkg::COARSE) && (next_state == cdu_pkg::COARSE) &&
                     !bus.coarse_err)
                    ? hold_cnt + DIV_W'(1) : '0;

      bus.cnt_up <= 1'b0;
      bus.cnt_dn <= 1'b0;
      bus.ATpPGH <= 1'b0;
      bus.ATmPGH <= 1'b0;
      // A reversal costs one whole period: the terminal count where the
      // direction first differs only records the new direction.
      if (want) begin
        if (bus.err_dir == dir_q) begin
          bus.cnt_up <= bus.err_dir;
          bus.cnt_dn <= !bus.err_dir;
          bus.ATpPGH <= bus.err_dir & bus.AGCEEC;
          bus.ATmPGH <= !bus.err_dir & bus.AGCEEC;
        end else begin
          dir_q <= bus.err_dir;
        end
      end
    end
  end

endmodule : cdu_count_sequencer

`default_nettype wire

// File: tb/tb_cdu_count_sequencer.sv
//==============================================================================
// Module      : tb_cdu_count_sequencer
// Description : Directed self-checking bench for cdu_count_sequencer with
//               default parameters (HI_DIV=4, LO_DIV=64, SETTLE=16,
//               FINE_HOLD=8).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_cdu_count_sequencer;

  import cdu_pkg::*;

  logic CLOCKH = 1'b0;
  logic rst_n  = 1'b1;
  int   compared   = 0;
  int   mismatched = 0;

  cdu_count_sequencer_if bus ();

  cdu_count_sequencer dut (
    .CLOCKH (CLOCKH),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 CLOCKH = ~CLOCKH;

  // Advance one clock; sample and drive 1 time unit after the rising edge
  task automatic tick();
    @(posedge CLOCKH);
    #1;
  endtask

  task automatic test_reset();
    int bad;
    bus.AGCZ = 1'b0; bus.AGCEEC = 1'b0; bus.coarse_err = 1'b0;
    bus.fine_err = 1'b0; bus.err_dir = 1'b0;
    #2 rst_n = 1'b0;
    #2;
    compared++;
    if (bus.mode !== ZERO) begin
      mismatched++; $display("FAIL reset_mode: got %0d want %0d", bus.mode, ZERO);
    end
    compared++;
    if ({bus.cnt_clr, bus.cnt_up, bus.cnt_dn, bus.ATpPGH, bus.ATmPGH} !== 5'b10000) begin
      mismatched++;
      $display("FAIL reset_outputs: got %b want 10000",
               {bus.cnt_clr, bus.cnt_up, bus.cnt_dn, bus.ATpPGH, bus.ATmPGH});
    end
    repeat (3) tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (bus.mode !== ZERO || bus.cnt_clr !== 1'b1 || bus.cnt_up !== 1'b0 ||
          bus.cnt_dn !== 1'b0 || bus.ATpPGH !== 1'b0 || bus.ATmPGH !== 1'b0) bad++;
    end
    compared++;
    if (bad !== 0) begin
      mismatched++; $display("FAIL zero_hold: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_settle();
    int n;
    int clr_bad;
    bus.coarse_err = 1'b1; bus.err_dir = 1'b1; bus.AGCEEC = 1'b1;
    bus.AGCZ = 1'b1;
    tick();
    n = 0; clr_bad = 0;
    while (bus.mode === SETTLE && n < 40) begin
      if (bus.cnt_clr !== 1'b0) clr_bad++;
      n++;
      tick();
    end
    compared++;
    if (n !== 16) begin
      mismatched++; $display("FAIL settle_len: got %0d cycles want 16", n);
    end
    compared++;
    if (clr_bad !== 0) begin
      mismatched++; $display("FAIL settle_clr: got %0d cycles with cnt_clr want 0", clr_bad);
    end
    compared++;
    if (bus.mode !== COARSE) begin
      mismatched++; $display("FAIL settle_exit: got mode %0d want %0d", bus.mode, COARSE);
    end
  endtask

  task automatic test_coarse_up();
    int n;
    int pulses;
    int bad;
    // Reset left the stored direction at 0, so the first terminal count
    // only latches the new direction: first up strobe 8 cycles in.
    n = 0;
    do begin tick(); n++; end while (bus.cnt_up !== 1'b1 && n < 20);
    compared++;
    if (n !== 8) begin
      mismatched++; $display("FAIL coarse_first: got %0d cycles want 8", n);
    end
    pulses = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cnt_up === 1'b1) pulses++;
      if (bus.ATpPGH !== bus.cnt_up || bus.cnt_dn !== 1'b0 || bus.ATmPGH !== 1'b0) bad++;
      tick();
    end
    compared++;
    if (pulses !== 25) begin
      mismatched++; $display("FAIL coarse_rate: got %0d pulses want 25", pulses);
    end
    compared++;
    if (bad !== 0) begin
      mismatched++; $display("FAIL coarse_agc: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_hold_to_fine();
    int n;
    int left;
    bus.fine_err = 1'b1;
    bus.coarse_err = 1'b0;
    left = 0;
    repeat (7) begin tick(); if (bus.mode !== COARSE) left++; end
    bus.coarse_err = 1'b1;
    tick(); if (bus.mode !== COARSE) left++;
    bus.coarse_err = 1'b0;
    compared++;
    if (left !== 0) begin
      mismatched++; $display("FAIL hold_interrupted: got %0d non-coarse cycles want 0", left);
    end
    n = 0;
    while (bus.mode !== FINE && n < 20) begin tick(); n++; end
    compared++;
    if (n !== 8) begin
      mismatched++; $display("FAIL hold_to_fine: got %0d cycles want 8", n);
    end
    // Entry edge coincides with a coarse terminal count; it must be silent.
    compared++;
    if (bus.cnt_up !== 1'b0) begin
      mismatched++; $display("FAIL entry_strobe: got cnt_up=%b want 0", bus.cnt_up);
    end
    n = 0;
    do begin tick(); n++; end while (bus.cnt_up !== 1'b1 && n < 100);
    compared++;
    if (n !== 64) begin
      mismatched++; $display("FAIL fine_first: got %0d cycles want 64", n);
    end
    n = 0;
    do begin tick(); n++; end while (bus.cnt_up !== 1'b1 && n < 100);
    compared++;
    if (n !== 64) begin
      mismatched++; $display("FAIL fine_period: got %0d cycles want 64", n);
    end
  endtask

  task automatic test_dir_flip();
    int n;
    int ups;
    bus.err_dir = 1'b0;
    n = 0; ups = 0;
    do begin
      tick(); n++;
      if (bus.cnt_up === 1'b1) ups++;
    end while (bus.cnt_dn !== 1'b1 && n < 300);
    compared++;
    if (n !== 128) begin
      mismatched++; $display("FAIL flip_gap: got %0d cycles want 128", n);
    end
    compared++;
    if (ups !== 0 || bus.ATmPGH !== 1'b1) begin
      mismatched++; $display("FAIL flip_pulses: got ups=%0d ATmPGH=%b want 0 and 1", ups, bus.ATmPGH);
    end
  endtask

  task automatic test_zero_abort();
    int n;
    bus.coarse_err = 1'b1;
    tick();
    compared++;
    if (bus.mode !== COARSE) begin
      mismatched++; $display("FAIL fine_to_coarse: got mode %0d want %0d", bus.mode, COARSE);
    end
    n = 0;
    do begin tick(); n++; end while (bus.cnt_dn !== 1'b1 && n < 20);
    compared++;
    if (n !== 4) begin
      mismatched++; $display("FAIL coarse_dn_first: got %0d cycles want 4", n);
    end
    repeat (3) tick();
    bus.AGCZ = 1'b0;
    tick();
    compared++;
    if (bus.mode !== ZERO || bus.cnt_clr !== 1'b1) begin
      mismatched++; $display("FAIL abort_state: got mode %0d clr %b want %0d 1", bus.mode, bus.cnt_clr, ZERO);
    end
    compared++;
    if (bus.cnt_dn !== 1'b0 || bus.ATmPGH !== 1'b0) begin
      mismatched++; $display("FAIL abort_strobe: got dn %b atm %b want 0 0", bus.cnt_dn, bus.ATmPGH);
    end
  endtask

  task automatic test_no_eec();
    int n;
    int dns;
    int bad;
    bus.AGCEEC = 1'b0; bus.err_dir = 1'b0; bus.coarse_err = 1'b1;
    bus.AGCZ = 1'b1;
    n = 0;
    do begin tick(); n++; end while (bus.mode !== COARSE && n < 40);
    compared++;
    if (n !== 17) begin
      mismatched++; $display("FAIL rerun_settle: got %0d cycles want 17", n);
    end
    n = 0;
    do begin tick(); n++; end while (bus.cnt_dn !== 1'b1 && n < 20);
    compared++;
    if (n !== 4) begin
      mismatched++; $display("FAIL noeec_first: got %0d cycles want 4", n);
    end
    dns = 0; bad = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.cnt_dn === 1'b1) dns++;
      if (bus.ATmPGH !== 1'b0 || bus.ATpPGH !== 1'b0 || bus.cnt_up !== 1'b0) bad++;
      tick();
    end
    compared++;
    if (dns !== 25) begin
      mismatched++; $display("FAIL noeec_rate: got %0d pulses want 25", dns);
    end
    compared++;
    if (bad !== 0) begin
      mismatched++; $display("FAIL noeec_gate: got %0d bad cycles want 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_coarse_up();
    test_hold_to_fine();
    test_dir_flip();
    test_zero_abort();
    test_no_eec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_cdu_count_sequencer

`default_nettype wire
